sdram_xfer_sequencer: RTL and testbench
=======================================

SDRAM_XFER_SEQUENCER -- requirements
Module: sdram_xfer_sequencer

Interface
REQ-001 SHALL have parameter NUM_BURSTS, default 4: number of bursts per run; legal range 1..65535.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1024: maximum WAIT_RESP dwell; used only when the watchdog is compiled in.
REQ-003 SHALL have port sys_ref_clk_clk, input, 1: the single clock; all logic is rising-edge.
REQ-004 SHALL have port sys_ref_reset_reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port startsignal_export, input, 1: run request level from the HPS system; a rising edge starts a run.
REQ-006 SHALL have port sdramstartstop_beginbursttransfer, output, 1: one-cycle pulse per burst issued.
REQ-007 SHALL have port sdramstartstop_writeresponsevalid_n, input, 1: active-low, one-cycle pulse per completed burst.
REQ-008 SHALL have port donesignal_export, output, 1: run complete, or aborted when the watchdog is compiled in.
REQ-009 SHALL have port xfer_cycles, output, 32: cycle count of the last run, for HEX/LED display.
REQ-010 SHALL have port xfer_err, output, 1: sticky error flag for the current run.

Function
REQ-011 SHALL implement the states IDLE, ISSUE, WAIT_RESP, DONE, plus ERROR when compiled in.
REQ-012 SHALL register startsignal_export once; a rising edge is prev==0 and cur==1 in IDLE.
REQ-013 On a start edge SHALL go IDLE->ISSUE, clear xfer_cycles, burst count and xfer_err.
REQ-014 ISSUE SHALL last exactly one cycle with beginbursttransfer=1, then go to WAIT_RESP.
- The first begin pulse is asserted in the cycle after the start edge is sampled.
REQ-015 In WAIT_RESP, writeresponsevalid_n==0 SHALL increment the response count.
- If the count reaches NUM_BURSTS, go to DONE.
- Otherwise go to ISSUE on the next cycle.
REQ-016 xfer_cycles SHALL increment in every cycle spent in ISSUE or WAIT_RESP and saturate at 32'hFFFF_FFFF.
- The value is held in IDLE, DONE and ERROR.
REQ-017 DONE SHALL drive donesignal_export=1 until startsignal_export is sampled 0, then go to IDLE.
- Leaving DONE for IDLE takes one cycle.
REQ-018 Start edges outside IDLE SHALL be ignored, and no run is queued.
- Start still high on return to IDLE SHALL NOT retrigger; a fresh 0->1 transition is required.
REQ-019 A response pulse in IDLE, ISSUE, DONE or ERROR SHALL NOT be counted.
- It SHALL set xfer_err=1, held until the next run start or reset.
REQ-020 The burst and response counters SHALL be 16 bits wide; they never wrap within a run because of REQ-001.

Reset
REQ-021 Reset SHALL force state IDLE, beginbursttransfer=0, donesignal_export=0, xfer_cycles=0, xfer_err=0, all counters=0, and the start history register=0.
REQ-022 Reset asserted mid-run SHALL abort immediately with no further begin pulses.
- After release, a new start edge is required.

Configuration
REQ-023 Macro XFER_TIMEOUT_EN defined: a WAIT_RESP dwell counter runs.
- Reaching TIMEOUT_CYCLES without a response goes to ERROR.
- ERROR drives donesignal_export=1 and xfer_err=1, and exits to IDLE when start is 0.
REQ-024 Macro XFER_TIMEOUT_EN undefined: no dwell counter and no ERROR state; WAIT_RESP waits indefinitely.

Structure
REQ-025 A shared package SHALL hold:
- the state enum;
- the counter width constants (16 for bursts/responses, 32 for cycles);
- the default NUM_BURSTS and TIMEOUT_CYCLES.
REQ-026 Sub-module xfer_cycle_counter SHALL implement the 32-bit saturating counter with clear/enable inputs.
- It is instantiated once for xfer_cycles.

Verification
REQ-027 NUM_BURSTS=4, response 3 cycles after each begin -> 4 begin pulses, then done=1; xfer_cycles=16, xfer_err=0.
REQ-028 Start drops during DONE -> done=0 one cycle later; start re-raised -> new run, xfer_cycles cleared to 0 then counting.
REQ-029 Response pulse while IDLE -> xfer_err=1, no state change; next start edge -> xfer_err=0.
REQ-030 Reset asserted during the 2nd WAIT_RESP -> all outputs 0 in the same cycle; no begin pulse until a new start edge.
REQ-031 XFER_TIMEOUT_EN, TIMEOUT_CYCLES=8, no response -> ERROR after 8 WAIT_RESP cycles: done=1, xfer_err=1, xfer_cycles=9.
REQ-032 Start held high across run completion and return to IDLE -> no second run started.

Source files
------------

// File: rtl/sdram_xfer_sequencer_pkg.sv
// Shared definitions for the SDRAM transfer sequencer: state encoding,
// counter widths and parameter defaults.
// Build option: XFER_TIMEOUT_EN adds the ERROR state used by the watchdog.
package sdram_xfer_sequencer_pkg;

    localparam int BURST_CNT_W            = 16;
    localparam int CYCLE_CNT_W            = 32;
    localparam int DEFAULT_NUM_BURSTS     = 4;
    localparam int DEFAULT_TIMEOUT_CYCLES = 1024;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_RESP,
`ifdef XFER_TIMEOUT_EN
        ST_DONE,
        ST_ERROR
`else
        ST_DONE
`endif
    } xfer_state_t;

endpackage

// File: rtl/sdram_xfer_sequencer_xfer_cycle_counter.sv
// Saturating up-counter with synchronous clear and count enable.
// Clear wins over enable; the count sticks at all-ones.
module xfer_cycle_counter
    import sdram_xfer_sequencer_pkg::*;
#(
    parameter int WIDTH = CYCLE_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    // Count enabled cycles, hold at the top value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != {WIDTH{1'b1}})) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/sdram_xfer_sequencer.sv
// SDRAM transfer sequencer: on a start rising edge issues NUM_BURSTS
// begin-burst pulses, each waiting for its write response, then raises done
// until start is released. Reports the run length and a sticky error flag
// for responses arriving when none is expected.
// Build option: XFER_TIMEOUT_EN adds a WAIT_RESP watchdog that aborts the run
// into ERROR after TIMEOUT_CYCLES cycles without a response.
//
// state        | meaning
// ST_IDLE      | waiting for a fresh start edge
// ST_ISSUE     | one-cycle begin-burst pulse
// ST_WAIT_RESP | waiting for the write response of the issued burst
// ST_DONE      | run complete, done held until start is low
// ST_ERROR     | watchdog abort, done and err held until start is low
module sdram_xfer_sequencer
    import sdram_xfer_sequencer_pkg::*;
#(
    parameter int NUM_BURSTS     = DEFAULT_NUM_BURSTS,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                   sys_ref_clk_clk,
    input  logic                   sys_ref_reset_reset,
    input  logic                   startsignal_export,
    output logic                   sdramstartstop_beginbursttransfer,
    input  logic                   sdramstartstop_writeresponsevalid_n,
    output logic                   donesignal_export,
    output logic [CYCLE_CNT_W-1:0] xfer_cycles,
    output logic                   xfer_err
);

    localparam logic [BURST_CNT_W-1:0] LAST_BURST = BURST_CNT_W'(NUM_BURSTS);

    if ((NUM_BURSTS < 1) || (NUM_BURSTS > 65535) || (TIMEOUT_CYCLES < 1)) begin : g_param_check
        $error("sdram_xfer_sequencer: NUM_BURSTS or TIMEOUT_CYCLES out of range");
    end

    xfer_state_t            state, state_next;
    logic                   start_prev;
    logic                   resp;
    logic                   run_start;
    logic                   issue_pulse;
    logic                   done_lvl;
    logic                   cyc_en;
    logic                   stray_resp;
    logic                   err_q;
    logic [BURST_CNT_W-1:0] burst_cnt;
    logic [BURST_CNT_W-1:0] resp_cnt;
    logic [BURST_CNT_W-1:0] resp_cnt_inc;

    assign resp         = ~sdramstartstop_writeresponsevalid_n;
    assign run_start    = (state == ST_IDLE) && startsignal_export && !start_prev;
    assign resp_cnt_inc = resp_cnt + BURST_CNT_W'(1);

`ifdef XFER_TIMEOUT_EN
    localparam logic [31:0] DWELL_LAST = 32'(TIMEOUT_CYCLES - 1);
    logic [31:0] dwell;
    logic        timeout_hit;

    assign timeout_hit = (dwell == DWELL_LAST);

    // Dwell counter restarts every time WAIT_RESP is entered.
    always_ff @(posedge sys_ref_clk_clk or posedge sys_ref_reset_reset) begin
        if (sys_ref_reset_reset) begin
            dwell <= '0;
        end else if (state != ST_WAIT_RESP) begin
            dwell <= '0;
        end else begin
            dwell <= dwell + 32'd1;
        end
    end
`endif

    // State register and start history.
    always_ff @(posedge sys_ref_clk_clk or posedge sys_ref_reset_reset) begin
        if (sys_ref_reset_reset) begin
            state      <= ST_IDLE;
            start_prev <= 1'b0;
        end else begin
            state      <= state_next;
            start_prev <= startsignal_export;
        end
    end

    // Next-state and Moore outputs; responses outside WAIT_RESP are flagged as stray.
    always_comb begin
        state_next  = state;
        issue_pulse = 1'b0;
        done_lvl    = 1'b0;
        cyc_en      = 1'b0;
        stray_resp  = 1'b0;
        case (state)
            ST_IDLE: begin
                stray_resp = resp;
                if (run_start) begin
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                issue_pulse = 1'b1;
                cyc_en      = 1'b1;
                stray_resp  = resp;
                state_next  = ST_WAIT_RESP;
            end
            ST_WAIT_RESP: begin
                cyc_en = 1'b1;
                if (resp) begin
                    if ((resp_cnt_inc == LAST_BURST) && (burst_cnt == LAST_BURST)) begin
                        state_next = ST_DONE;
                    end else begin
                        state_next = ST_ISSUE;
                    end
                end
`ifdef XFER_TIMEOUT_EN
                else if (timeout_hit) begin
                    state_next = ST_ERROR;
                end
`endif
            end
            ST_DONE: begin
                done_lvl   = 1'b1;
                stray_resp = resp;
                if (!startsignal_export) begin
                    state_next = ST_IDLE;
                end
            end
`ifdef XFER_TIMEOUT_EN
            ST_ERROR: begin
                done_lvl   = 1'b1;
                stray_resp = resp;
                if (!startsignal_export) begin
                    state_next = ST_IDLE;
                end
            end
`endif
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Burst/response counters and sticky error, all cleared by a run start.
    always_ff @(posedge sys_ref_clk_clk or posedge sys_ref_reset_reset) begin
        if (sys_ref_reset_reset) begin
            burst_cnt <= '0;
            resp_cnt  <= '0;
            err_q     <= 1'b0;
        end else if (run_start) begin
            burst_cnt <= '0;
            resp_cnt  <= '0;
            err_q     <= 1'b0;
        end else begin
            if (state == ST_ISSUE) begin
                burst_cnt <= burst_cnt + BURST_CNT_W'(1);
            end
            if ((state == ST_WAIT_RESP) && resp) begin
                resp_cnt <= resp_cnt_inc;
            end
            if (stray_resp) begin
                err_q <= 1'b1;
            end
`ifdef XFER_TIMEOUT_EN
            if (state_next == ST_ERROR) begin
                err_q <= 1'b1;
            end
`endif
        end
    end

    xfer_cycle_counter #(
        .WIDTH (CYCLE_CNT_W)
    ) u_cycle_counter (
        .clk   (sys_ref_clk_clk),
        .rst   (sys_ref_reset_reset),
        .clr   (run_start),
        .en    (cyc_en),
        .count (xfer_cycles)
    );

    assign sdramstartstop_beginbursttransfer = issue_pulse;
    assign donesignal_export                 = done_lvl;
    assign xfer_err                          = err_q;

endmodule

// File: tb/tb_sdram_xfer_sequencer.sv
// Testbench for sdram_xfer_sequencer: directed scenarios plus randomized runs
// with random response latency and stray responses, checked cycle by cycle
// against expectations derived from the run/burst rules.
module tb_sdram_xfer_sequencer;

    localparam int NB = 4;
    localparam int TO = 8;

    logic        clk;
    logic        rst;
    logic        start;
    logic        resp_n;
    logic        issue;
    logic        done;
    logic [31:0] cycles;
    logic        err;

    int n_chk  = 0;
    int n_fail = 0;
    int exp_cycles;
    bit exp_err;

    sdram_xfer_sequencer #(
        .NUM_BURSTS     (NB),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .sys_ref_clk_clk                     (clk),
        .sys_ref_reset_reset                 (rst),
        .startsignal_export                  (start),
        .sdramstartstop_beginbursttransfer   (issue),
        .sdramstartstop_writeresponsevalid_n (resp_n),
        .donesignal_export                   (done),
        .xfer_cycles                         (cycles),
        .xfer_err                            (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Raise start from a sampled-low level; the begin pulse follows one cycle later.
    task automatic start_run();
        start = 1'b1;
        tick();
        exp_cycles = 0;
        exp_err    = 1'b0;
        chk("start_begin", 32'(issue), 32'd1);
        chk("start_cycles_clr", cycles, 32'd0);
        chk("start_err_clr", 32'(err), 32'd0);
    endtask

    // Called at the negedge of an ISSUE cycle; respond in the lat-th WAIT_RESP cycle.
    task automatic burst(input int lat, input bit stray_issue, input bit last);
        if (stray_issue) begin
            resp_n  = 1'b0;
            exp_err = 1'b1;
        end
        for (int j = 1; j <= lat; j++) begin
            tick();
            resp_n = (j == lat) ? 1'b0 : 1'b1;
            chk("wait_no_begin", 32'(issue), 32'd0);
            chk("wait_cycles", cycles, 32'(exp_cycles + j));
        end
        tick();
        resp_n = 1'b1;
        exp_cycles += 1 + lat;
        if (last) begin
            chk("last_done", 32'(done), 32'd1);
            chk("last_no_begin", 32'(issue), 32'd0);
        end else begin
            chk("next_begin", 32'(issue), 32'd1);
            chk("next_not_done", 32'(done), 32'd0);
        end
    endtask

    task automatic finish_run(input bit stray_done);
        chk("done_level", 32'(done), 32'd1);
        chk("done_cycles", cycles, 32'(exp_cycles));
        chk("done_err", 32'(err), 32'(exp_err));
        if (stray_done) begin
            resp_n = 1'b0;
            tick();
            resp_n  = 1'b1;
            exp_err = 1'b1;
            chk("done_stray_err", 32'(err), 32'd1);
            chk("done_stray_hold", 32'(done), 32'd1);
        end
        start = 1'b0;
        tick();
        chk("release_done", 32'(done), 32'd0);
        chk("idle_cycles_hold", cycles, 32'(exp_cycles));
        chk("idle_err_hold", 32'(err), 32'(exp_err));
    endtask

    task automatic idle_stray();
        resp_n = 1'b0;
        tick();
        resp_n = 1'b1;
        chk("idle_stray_err", 32'(err), 32'd1);
        chk("idle_stray_no_begin", 32'(issue), 32'd0);
        chk("idle_stray_no_done", 32'(done), 32'd0);
        tick();
        chk("idle_stray_still_idle", 32'(issue), 32'd0);
    endtask

    initial begin
        int nbeg;
        rst    = 1'b1;
        start  = 1'b0;
        resp_n = 1'b1;
        repeat (2) tick();
        chk("rst_begin", 32'(issue), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_cycles", cycles, 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        rst = 1'b0;
        repeat (2) tick();

        // Four bursts, response three cycles after each begin.
        start_run();
        for (int b = 0; b < NB; b++) burst(3, 1'b0, b == NB - 1);
        chk("basic_cycles16", cycles, 32'd16);
        chk("basic_err0", 32'(err), 32'd0);
        finish_run(1'b0);

        // Re-raise start: counter restarts from zero.
        start_run();
        for (int b = 0; b < NB; b++) burst(2, 1'b0, b == NB - 1);
        finish_run(1'b0);

        // Stray response while idle, then cleared by the next start.
        idle_stray();
        start_run();
        for (int b = 0; b < NB; b++) burst(1, 1'b0, b == NB - 1);
        finish_run(1'b0);

        // Reset during the second WAIT_RESP.
        start_run();
        burst(1, 1'b0, 1'b0);
        tick();
        rst   = 1'b1;
        start = 1'b0;
        #1;
        chk("midrst_begin", 32'(issue), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_cycles", cycles, 32'd0);
        chk("midrst_err", 32'(err), 32'd0);
        tick();
        rst  = 1'b0;
        nbeg = 0;
        repeat (8) begin
            tick();
            if (issue) nbeg++;
        end
        chk("midrst_no_begin", 32'(nbeg), 32'd0);
        start_run();
        for (int b = 0; b < NB; b++) burst(1, 1'b0, b == NB - 1);
        finish_run(1'b0);

        // Start toggled mid-run and held high past completion: nothing queued.
        start_run();
        start = 1'b0;
        burst(3, 1'b0, 1'b0);
        start = 1'b1;
        for (int b = 1; b < NB; b++) burst(3, 1'b0, b == NB - 1);
        nbeg = 0;
        repeat (20) begin
            tick();
            if (issue) nbeg++;
        end
        chk("held_no_second_run", 32'(nbeg), 32'd0);
        chk("held_done", 32'(done), 32'd1);
        finish_run(1'b0);
        nbeg = 0;
        repeat (5) begin
            tick();
            if (issue) nbeg++;
        end
        chk("idle_quiet", 32'(nbeg), 32'd0);

`ifdef XFER_TIMEOUT_EN
        // No response: watchdog aborts after TO cycles in WAIT_RESP.
        start_run();
        repeat (TO) tick();
        chk("to_not_yet", 32'(done), 32'd0);
        tick();
        chk("to_done", 32'(done), 32'd1);
        chk("to_err", 32'(err), 32'd1);
        chk("to_cycles", cycles, 32'(TO + 1));
        start = 1'b0;
        tick();
        chk("to_release", 32'(done), 32'd0);
        chk("to_err_hold", 32'(err), 32'd1);
`endif

        // Randomized runs.
        for (int r = 0; r < 25; r++) begin
            if ($urandom_range(0, 3) == 0) idle_stray();
            repeat ($urandom_range(0, 3)) tick();
            start_run();
            for (int b = 0; b < NB; b++) begin
                burst(int'($urandom_range(1, 6)), $urandom_range(0, 4) == 0, b == NB - 1);
            end
            finish_run($urandom_range(0, 3) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
